// File: rtl/mlp_pkg.sv
// mlp_pkg: neuron FSM states, default widths and accumulator width derivation
package mlp_pkg;
  typedef enum logic [1:0] {IDLE, MAC, ACT, HOLD} state_t;
  localparam int N_IN_DEF  = 4;
  localparam int IN_W_DEF  = 8;
  localparam int W_W_DEF   = 8;
  localparam int OUT_W_DEF = 10;
  function automatic int acc_width(int in_w, int w_w, int n_in);
    return in_w + w_w + $clog2(n_in) + 1;
  endfunction
endpackage

// File: rtl/neuron_mac_unit.sv
// neuron_mac_unit: signed MAC (ports clk/rst, clr, load with bias, en adds a*b, acc out)
module neuron_mac_unit import mlp_pkg::*; #(
  parameter int IN_W  = IN_W_DEF,
  parameter int W_W   = W_W_DEF,
  parameter int ACC_W = 19
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    load,
  input  logic                    en,
  input  logic signed [W_W-1:0]   bias,
  input  logic signed [IN_W-1:0]  a,
  input  logic signed [W_W-1:0]   b,
  output logic signed [ACC_W-1:0] acc
);
  logic signed [IN_W+W_W-1:0] prod;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  assign prod = a * b;
  assign acc  = acc_q;
  always_comb
    acc_d = clr  ? '0 :
            load ? {{(ACC_W-W_W){bias[W_W-1]}}, bias} :
            en   ? acc_q + {{(ACC_W-IN_W-W_W){prod[IN_W+W_W-1]}}, prod} : acc_q;
  always_ff @(posedge clk)
    if (rst) acc_q <= '0;
    else acc_q <= acc_d;
endmodule

// File: rtl/neuron_mac.sv
// neuron_mac: N_IN-input neuron (in_valid/in_ready/in_data/weights/bias in, out_valid/out_ready/out_data out, busy); NEURON_RELU_EN selects ReLU else linear clamp
module neuron_mac import mlp_pkg::*; #(
  parameter int N_IN  = N_IN_DEF,
  parameter int IN_W  = IN_W_DEF,
  parameter int W_W   = W_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_IN*IN_W-1:0] in_data,
  input  logic [N_IN*W_W-1:0]  weights,
  input  logic [W_W-1:0]       bias,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_data,
  output logic                 busy
);
  localparam int ACC_W = acc_width(IN_W, W_W, N_IN);
  localparam int IDX_W = $clog2(N_IN);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_IN - 1);
`ifdef NEURON_RELU_EN
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(2 ** OUT_W - 1);
`else
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(2 ** (OUT_W - 1)));
`endif
  state_t state_q, state_d;
  logic [N_IN*IN_W-1:0] in_q, in_d;
  logic [N_IN*W_W-1:0] w_q, w_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] out_q, out_d, act_val;
  logic signed [ACC_W-1:0] acc;
  logic accept, done;
  assign accept    = in_valid && state_q == IDLE;
  assign done      = out_ready && state_q == HOLD;
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == HOLD;
  assign busy      = state_q != IDLE;
  assign out_data  = out_q;
`ifdef NEURON_RELU_EN
  assign act_val = acc <= 0 ? '0 : acc > SAT_HI ? SAT_HI[OUT_W-1:0] : acc[OUT_W-1:0];
`else
  assign act_val = acc > SAT_HI ? SAT_HI[OUT_W-1:0] :
                   acc < SAT_LO ? SAT_LO[OUT_W-1:0] : acc[OUT_W-1:0];
`endif
  always_comb begin
    state_d = state_q;
    in_d    = in_q;
    w_d     = w_q;
    idx_d   = idx_q;
    out_d   = out_q;
    case (state_q)
      IDLE: if (in_valid) begin
        in_d    = in_data;
        w_d     = weights;
        idx_d   = '0;
        state_d = MAC;
      end
      MAC: begin
        idx_d   = idx_q == LAST ? '0 : idx_q + 1'b1;
        state_d = idx_q == LAST ? ACT : MAC;
      end
      ACT: begin
        out_d   = act_val;
        state_d = HOLD;
      end
      HOLD: state_d = out_ready ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      in_q    <= '0;
      w_q     <= '0;
      idx_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      w_q     <= w_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
    end
  neuron_mac_unit #(.IN_W(IN_W), .W_W(W_W), .ACC_W(ACC_W)) u_mac (
    .clk  (clk),
    .rst  (rst),
    .clr  (done),
    .load (accept),
    .en   (state_q == MAC),
    .bias (bias),
    .a    (in_q[idx_q*IN_W +: IN_W]),
    .b    (w_q[idx_q*W_W +: W_W]),
    .acc  (acc)
  );
endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: randomized and directed checks of neuron_mac against an arithmetic model
module tb_neuron_mac;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] in_data, weights;
  logic [7:0] bias;
  logic [9:0] out_data;
  int passed = 0, total = 0;
  int xv[4], wv[4], bv;
  int lat;
  neuron_mac #(.N_IN(4), .IN_W(8), .W_W(8), .OUT_W(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .weights(weights), .bias(bias),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [9:0] model();
    int s = bv;
    for (int i = 0; i < 4; i++) s += xv[i] * wv[i];
`ifdef NEURON_RELU_EN
    if (s <= 0) s = 0;
    else if (s > 1023) s = 1023;
`else
    if (s > 511) s = 511;
    else if (s < -512) s = -512;
`endif
    return 10'(s);
  endfunction
  task automatic apply();
    for (int i = 0; i < 4; i++) begin
      in_data[i*8 +: 8] = 8'(xv[i]);
      weights[i*8 +: 8] = 8'(wv[i]);
    end
    bias = 8'(bv);
  endtask
  task automatic randomize_vec();
    for (int i = 0; i < 4; i++) begin
      xv[i] = int'($urandom_range(255)) - 128;
      wv[i] = int'($urandom_range(255)) - 128;
    end
    bv = int'($urandom_range(255)) - 128;
  endtask
  task automatic send();
    int n = 0;
    @(negedge clk);
    apply();
    in_valid = 1'b1;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 32'($urandom);
    weights  = 32'($urandom);
    bias     = 8'($urandom);
  endtask
  task automatic wait_valid();
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; weights = '0; bias = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
    total++; if (out_data !== 10'd0) $display("FAIL reset_out_data got %h want 000", out_data); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
  endtask
  task automatic test_basic();
    xv = '{1, 2, 3, 4}; wv = '{1, 1, 1, 1}; bv = 5;
    out_ready = 1'b1;
    send();
    total++; if (busy !== 1'b1 || in_ready !== 1'b0) $display("FAIL basic_busy got busy=%b in_ready=%b want 1/0", busy, in_ready); else passed++;
    wait_valid();
    total++; if (lat !== 6) $display("FAIL basic_latency got %0d want 6", lat); else passed++;
    total++; if (out_data !== 10'd15) $display("FAIL basic_data got %0d want 15", out_data); else passed++;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) $display("FAIL basic_one_cycle got %b want 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL basic_ready_back got %b want 1", in_ready); else passed++;
  endtask
  task automatic test_negative();
    logic [9:0] exp_v;
    xv = '{10, 10, 10, 10}; wv = '{-3, -3, -3, -3}; bv = 0;
`ifdef NEURON_RELU_EN
    exp_v = 10'd0;
`else
    exp_v = 10'h388;
`endif
    send();
    wait_valid();
    total++; if (out_data !== exp_v) $display("FAIL negative_data got %h want %h", out_data, exp_v); else passed++;
    @(negedge clk);
  endtask
  task automatic test_saturate();
    logic [9:0] exp_v;
    xv = '{127, 127, 127, 127}; wv = '{127, 127, 127, 127}; bv = 127;
`ifdef NEURON_RELU_EN
    exp_v = 10'd1023;
`else
    exp_v = 10'd511;
`endif
    send();
    wait_valid();
    total++; if (out_data !== exp_v) $display("FAIL saturate_data got %h want %h", out_data, exp_v); else passed++;
    @(negedge clk);
  endtask
  task automatic test_hold_stall();
    logic [9:0] exp_v;
    randomize_vec();
    exp_v = model();
    out_ready = 1'b0;
    send();
    wait_valid();
    for (int k = 0; k < 5; k++) begin
      total++; if (out_valid !== 1'b1) $display("FAIL stall_valid[%0d] got %b want 1", k, out_valid); else passed++;
      total++; if (out_data !== exp_v) $display("FAIL stall_data[%0d] got %h want %h", k, out_data, exp_v); else passed++;
      total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready[%0d] got %b want 0", k, in_ready); else passed++;
      in_valid = k[0];
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL stall_release got valid=%b ready=%b want 0/1", out_valid, in_ready); else passed++;
    repeat (3) @(negedge clk);
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL stall_no_queue got valid=%b busy=%b want 0/0", out_valid, busy); else passed++;
  endtask
  task automatic test_reset_mid();
    xv = '{1, 2, 3, 4}; wv = '{1, 1, 1, 1}; bv = 5;
    out_ready = 1'b1;
    send();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (out_valid !== 1'b0) $display("FAIL midrst_valid got %b want 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL midrst_idle got ready=%b busy=%b want 1/0", in_ready, busy); else passed++;
    send();
    wait_valid();
    total++; if (lat !== 6 || out_data !== 10'd15) $display("FAIL midrst_result got lat=%0d data=%0d want 6/15", lat, out_data); else passed++;
    @(negedge clk);
  endtask
  task automatic test_random();
    logic [9:0] exp_v;
    for (int t = 0; t < 10; t++) begin
      randomize_vec();
      exp_v = model();
      out_ready = 1'b0;
      send();
      repeat ($urandom_range(7)) @(negedge clk);
      out_ready = 1'b1;
      wait_valid();
      total++; if (out_data !== exp_v) $display("FAIL random_data[%0d] got %h want %h", t, out_data, exp_v); else passed++;
      @(negedge clk);
    end
  endtask
  task automatic test_back_to_back();
    logic [9:0] exp_a, exp_b;
    int n = 0;
    out_ready = 1'b1;
    randomize_vec();
    exp_a = model();
    @(negedge clk);
    apply();
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    randomize_vec();
    exp_b = model();
    apply();
    wait_valid();
    total++; if (lat !== 6 || out_data !== exp_a) $display("FAIL b2b_first got lat=%0d data=%h want 6/%h", lat, out_data, exp_a); else passed++;
    @(negedge clk);
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL b2b_gap got ready=%b valid=%b want 1/0", in_ready, out_valid); else passed++;
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (busy !== 1'b1) $display("FAIL b2b_second_accept got busy=%b want 1", busy); else passed++;
    wait_valid();
    total++; if (lat !== 6 || out_data !== exp_b) $display("FAIL b2b_second got lat=%0d data=%h want 6/%h", lat, out_data, exp_b); else passed++;
    @(negedge clk);
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++; if (busy !== 1'b0) $display("FAIL b2b_idle got busy=%b want 0", busy); else passed++;
  endtask
  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_saturate();
    test_hold_stall();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/neuron_mac.md
NEURON_MAC -- requirements
Module: neuron_mac

Interface
REQ-001 SHALL have parameter N_IN, default 4, number of inputs/weights per neuron (>=2).
REQ-002 SHALL have parameter IN_W, default 8, width of each signed input.
REQ-003 SHALL have parameter W_W, default 8, width of each signed weight and of the bias.
REQ-004 SHALL have parameter OUT_W, default 10, width of the activation output.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port in_valid  input  1  input vector and weights valid.
REQ-008 SHALL have port in_ready  output  1  block can accept a new vector.
REQ-009 SHALL have port in_data  input  N_IN*IN_W  packed signed inputs, element 0 in LSBs.
REQ-010 SHALL have port weights  input  N_IN*W_W  packed signed weights, element 0 in LSBs.
REQ-011 SHALL have port bias  input  W_W  signed bias.
REQ-012 SHALL have port out_valid  output  1  out_data holds a result.
REQ-013 SHALL have port out_ready  input  1  consumer accepts result.
REQ-014 SHALL have port out_data  output  OUT_W  activated, saturated result.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, MAC, ACT, HOLD.
REQ-017 SHALL assert in_ready only in IDLE; accept occurs on in_valid && in_ready at a rising edge.
REQ-018 On accept SHALL register in_data, weights, bias, load accumulator with sign-extended bias, clear index, go to MAC.
REQ-019 In MAC SHALL add in[idx]*w[idx] (signed, full product) per cycle, idx 0..N_IN-1, exactly N_IN cycles, then go to ACT.
REQ-020 Accumulator width SHALL be ACC_W = IN_W+W_W+clog2(N_IN)+1; no internal overflow possible.
REQ-021 In ACT SHALL apply activation and saturation (REQ-031/032), register out_data, go to HOLD.
REQ-022 In HOLD SHALL drive out_valid high; out_data and out_valid SHALL stay stable until out_valid && out_ready.
REQ-023 On output handshake SHALL return to IDLE; in_ready SHALL rise the following cycle (no same-cycle re-accept).
REQ-024 out_valid SHALL first be high N_IN+2 cycles after the accept edge when out_ready is already high.
REQ-025 Input port changes after accept SHALL NOT affect the in-flight result.
REQ-026 in_valid while not in IDLE SHALL be ignored (not queued).

Reset
REQ-027 rst SHALL override all other inputs in the cycle it is sampled, including mid-MAC or in HOLD.
REQ-028 After reset: state IDLE, out_valid=0, out_data=0, in_ready=1, busy=0, accumulator and index=0.
REQ-029 An interrupted computation SHALL be discarded; no partial result is ever presented.

Configuration
REQ-030 Macro NEURON_RELU_EN SHALL select the activation.
REQ-031 With NEURON_RELU_EN defined: acc<=0 -> 0; acc>2^OUT_W-1 -> 2^OUT_W-1; else acc; out_data unsigned.
REQ-032 Without NEURON_RELU_EN: linear; out_data signed two's complement clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].

Structure
REQ-033 Package mlp_pkg SHALL hold the FSM state enum, default width constants, and the ACC_W derivation function.
REQ-034 Multiply-accumulate datapath SHALL be a sub-module neuron_mac_unit (signed multiply, accumulate, load, clear); FSM, operand mux and activation stay in neuron_mac.

Verification (N_IN=4, IN_W=8, W_W=8, OUT_W=10)
REQ-035 Inputs 1,2,3,4; weights 1,1,1,1; bias 5; out_ready=1 -> out_data=15, out_valid high exactly 6 cycles after accept edge, one cycle.
REQ-036 Inputs 10,10,10,10; weights -3 each; bias 0 -> with RELU_EN out_data=0; without, out_data=10'h388 (-120).
REQ-037 Inputs 127 each; weights 127 each; bias 127 (acc=64643) -> with RELU_EN 1023; without 511.
REQ-038 out_ready low 5 cycles in HOLD -> out_data/out_valid stable, in_ready=0, in_valid pulses ignored; result consumed once when out_ready rises.
REQ-039 rst asserted 2 cycles into MAC -> next cycle out_valid=0, in_ready=1; following vector from REQ-035 yields 15 unaffected.
REQ-040 Back-to-back: in_valid held high with two vectors -> second accepted one cycle after first result handshake; both results correct, in order.
